pulse_event_queue: RTL and testbench
====================================

# pulse_event_queue

Destination-domain consumer of single-cycle event pulses produced by the toggle synchronizer. Counts pulses into a saturating pending counter and presents them one at a time on a valid/ready handshake with a wrapping sequence tag. Dropped events are flagged sticky and counted, so no crossed event is lost silently. Sits directly after the synchronizer output in the clkB domain.

## Interface
- CNT_W, 4: pending counter width; MAX_PENDING = 2**CNT_W - 1
- SEQ_W, 3: sequence tag width
- DROP_W, 8: dropped-event counter width (saturating)

- clkB  in  1  sole clock (destination domain)
- resetn  in  1  asynchronous, active-low reset
- evt_pulse  in  1  single-cycle event pulse (synchronizer sig_sync)
- evt_valid  out  1  an event is offered downstream
- evt_ready  in  1  downstream accepts; handshake = evt_valid & evt_ready
- evt_seq  out  SEQ_W  tag of the offered event
- pending  out  CNT_W  events held, including the one offered
- overflow  out  1  sticky: at least one pulse dropped
- ovf_clr  in  1  clears overflow and drop_cnt
- drop_cnt  out  DROP_W  dropped pulses, saturating at all-ones

- One clock; reset is asynchronous and active-low, on resetn.

## Operation
- FSM state enum: IDLE (pending == 0, evt_valid low) and OFFER (pending > 0, evt_valid high).
- IDLE -> OFFER on evt_pulse.
- OFFER -> IDLE on a handshake with pending == 1 and no evt_pulse that cycle.
- OFFER stays OFFER otherwise.
- Per cycle, with inc = evt_pulse & (pending < MAX_PENDING | hs) and hs = handshake:
  - inc & !hs: pending + 1
  - hs & !inc: pending - 1
  - both or neither: unchanged
- Full case: evt_pulse with pending == MAX_PENDING and no hs is a drop.
  - pending is unchanged.
  - overflow is set.
  - drop_cnt increments, saturating.
- Full case with hs in the same cycle: the pulse is accepted and pending is net unchanged (no drop).
- evt_seq increments modulo 2**SEQ_W on each handshake. The first event after reset carries tag 0.
- evt_valid never deasserts without a handshake. evt_seq is stable while evt_valid is high and evt_ready is low.
- ovf_clr clears overflow and drop_cnt next cycle. A drop in the same cycle as ovf_clr wins: overflow = 1, drop_cnt = 1.
- evt_ready while in IDLE has no effect.

## Timing
- Reset (async assert; the deassert edge is synchronized by the parent) forces:
  - state IDLE
  - pending = 0, evt_valid = 0, evt_seq = 0
  - overflow = 0, drop_cnt = 0
- Reset asserted mid-operation discards all pending events immediately, with no handshake.
- All outputs are registered; there is no combinational path from evt_ready or evt_pulse to any output.
- Latency: evt_pulse in cycle n gives evt_valid high and the pending update in cycle n+1.
- Handshake in cycle n: the next tag and the decremented pending are visible in cycle n+1. Back-to-back handshakes sustain one event per cycle.
- Pulse and handshake in the same cycle: evt_valid stays high.

## Structure
- Package pulse_event_pkg holds:
  - the state_t enum {IDLE, OFFER}
  - default values for CNT_W, SEQ_W and DROP_W
- There is no sub-module; the pending counter, tag counter and drop counter are inline.
- The parent instantiates the toggle synchronizer and connects sig_sync to evt_pulse.

## Test plan
- Single event: reset, then evt_pulse at cycle 5 with evt_ready = 1.
  - evt_valid high at cycle 6, seq = 0.
  - Handshake at cycle 6.
  - Cycle 7: pending = 0 and evt_valid = 0.
- Accumulate: 3 pulses with evt_ready = 0 -> pending = 3. Then evt_ready = 1 for 3 cycles -> tags 0, 1, 2 handshake in consecutive cycles, then IDLE.
- Full and drop: with evt_ready = 0, send 17 pulses.
  - pending = 15.
  - overflow = 1, drop_cnt = 2.
  - Pulse plus handshake at full -> pending stays 15, drop_cnt unchanged.
- Clear collision: ovf_clr together with a drop -> overflow = 1, drop_cnt = 1. ovf_clr alone afterwards -> both read 0.
- Wrap: 9 events with SEQ_W = 3 -> tags 0..7, then 0.
- Reset mid-queue: pending = 5 and evt_valid = 1, then assert resetn = 0 between clock edges -> outputs zero immediately. After release, the first event carries tag 0.

Source files
------------

// File: rtl/pulse_event_pkg.sv
// Shared types and default widths for the clkB-side event pulse queue.
package pulse_event_pkg;

  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned SEQ_W_DEF  = 3;
  localparam int unsigned DROP_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/pulse_event_queue.sv
// Counts synchronized event pulses and offers them one at a time on a
// valid/ready handshake with a wrapping tag; drops at full are flagged and counted.
module pulse_event_queue
  import pulse_event_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned SEQ_W  = SEQ_W_DEF,
  parameter int unsigned DROP_W = DROP_W_DEF
) (
  input  logic              clkB,
  input  logic              resetn,
  input  logic              evt_pulse,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [SEQ_W-1:0]  evt_seq,
  output logic [CNT_W-1:0]  pending,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0]  MAX_PENDING = '1;
  localparam logic [DROP_W-1:0] DROP_MAX    = '1;

  state_t              state_q, state_d;
  logic                evt_valid_q, evt_valid_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [CNT_W-1:0]    pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic hs_c;
  logic full_c;
  logic inc_c;
  logic drop_c;

  // Next-state: handshake, pending/tag/drop counters and offer state.
  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    seq_d       = seq_q;
    pending_d   = pending_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;

    hs_c   = evt_valid_q & evt_ready;
    full_c = (pending_q == MAX_PENDING);
    // A pulse at full still fits if a slot frees up in the same cycle.
    inc_c  = evt_pulse & (~full_c | hs_c);
    drop_c = evt_pulse & full_c & ~hs_c;

    if (inc_c && !hs_c) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (hs_c && !inc_c) begin
      pending_d = pending_q - CNT_W'(1);
    end

    if (hs_c) begin
      seq_d = seq_q + SEQ_W'(1);
    end

    // A drop in the same cycle as a clear restarts the count at one.
    if (drop_c) begin
      overflow_d = 1'b1;
      if (ovf_clr) begin
        drop_cnt_d = DROP_W'(1);
      end else if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (evt_pulse) begin
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (hs_c && (pending_q == CNT_W'(1)) && !evt_pulse) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    evt_valid_d = (state_d == OFFER);
  end

  always_ff @(posedge clkB or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      seq_q       <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      seq_q       <= seq_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_seq   = seq_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pulse_event_queue.sv
// Directed bench for pulse_event_queue with a tag scoreboard and a small occupancy model.
module tb_pulse_event_queue;

  logic       clkB;
  logic       resetn;
  logic       evt_pulse;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_seq;
  logic [3:0] pending;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] drop_cnt;

  pulse_event_queue dut (
    .clkB      (clkB),
    .resetn    (resetn),
    .evt_pulse (evt_pulse),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_seq   (evt_seq),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt)
  );

  initial clkB = 1'b0;
  always #5 clkB = ~clkB;

  int checks = 0;
  int errors = 0;

  int   sb[$];
  int   push_tag;
  int   m_pend;
  int   m_ovf;
  int   m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    push_tag = 0;
    m_pend   = 0;
    m_ovf    = 0;
    m_drop   = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pending"},  32'(pending),   32'(m_pend));
    chk({tag, "_valid"},    32'(evt_valid), 32'(m_pend != 0));
    chk({tag, "_overflow"}, 32'(overflow),  32'(m_ovf));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt),  32'(m_drop));
    if (m_pend != 0 && sb.size() != 0) begin
      chk({tag, "_seq_front"}, 32'(evt_seq), 32'(sb[0]));
    end
  endtask

  // One clock: model the edge at negedge, then check outputs just after posedge.
  task automatic tick(input string tag);
    bit mhs, minc, mdrop;
    @(negedge clkB);
    mhs   = (m_pend != 0) && evt_ready;
    minc  = evt_pulse && ((m_pend < 15) || mhs);
    mdrop = evt_pulse && !minc;
    if (mhs) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'(1), 32'(0));
      end else begin
        chk({tag, "_hs_seq"}, 32'(evt_seq), 32'(sb.pop_front()));
      end
    end
    if (minc) begin
      sb.push_back(push_tag);
      push_tag = (push_tag + 1) % 8;
    end
    m_pend = m_pend + int'(minc) - int'(mhs);
    if (mdrop) begin
      m_ovf  = 1;
      m_drop = ovf_clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (ovf_clr) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    @(posedge clkB);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] seq_hold;
    resetn    = 1'b0;
    evt_pulse = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();

    repeat (2) @(posedge clkB);
    #1;
    chk("rst_pending",  32'(pending),   32'(0));
    chk("rst_valid",    32'(evt_valid), 32'(0));
    chk("rst_seq",      32'(evt_seq),   32'(0));
    chk("rst_overflow", 32'(overflow),  32'(0));
    chk("rst_drop_cnt", 32'(drop_cnt),  32'(0));
    resetn = 1'b1;

    // Ready in IDLE does nothing.
    evt_ready = 1'b1;
    repeat (3) tick("idle_ready");
    chk("idle_seq", 32'(evt_seq), 32'(0));

    // Single event with ready high: offered next cycle, accepted the cycle after.
    evt_pulse = 1'b1;
    tick("single_pulse");
    evt_pulse = 1'b0;
    chk("single_valid", 32'(evt_valid), 32'(1));
    chk("single_seq",   32'(evt_seq),   32'(0));
    chk("single_pend",  32'(pending),   32'(1));
    tick("single_hs");
    chk("single_done_valid", 32'(evt_valid), 32'(0));
    chk("single_done_pend",  32'(pending),   32'(0));

    // Accumulate three then drain back-to-back.
    evt_ready = 1'b0;
    evt_pulse = 1'b1;
    repeat (3) tick("acc_pulse");
    evt_pulse = 1'b0;
    chk("acc_pend3", 32'(pending), 32'(3));
    seq_hold = evt_seq;
    tick("acc_hold");
    chk("acc_seq_stable", 32'(evt_seq), 32'(seq_hold));
    evt_ready = 1'b1;
    repeat (3) tick("acc_drain");
    chk("acc_idle", 32'(evt_valid), 32'(0));

    // Fill past capacity: 15 held, 2 dropped.
    evt_ready = 1'b0;
    evt_pulse = 1'b1;
    repeat (17) tick("fill");
    chk("full_pend",     32'(pending),  32'(15));
    chk("full_overflow", 32'(overflow), 32'(1));
    chk("full_drops",    32'(drop_cnt), 32'(2));
    evt_ready = 1'b1;
    tick("full_pulse_hs");
    chk("full_hs_pend",  32'(pending),  32'(15));
    chk("full_hs_drops", 32'(drop_cnt), 32'(2));
    chk("full_hs_valid", 32'(evt_valid), 32'(1));

    // Drop colliding with a clear, then a clear alone.
    evt_ready = 1'b0;
    ovf_clr   = 1'b1;
    tick("clr_collide");
    evt_pulse = 1'b0;
    chk("clr_col_ovf",  32'(overflow), 32'(1));
    chk("clr_col_drop", 32'(drop_cnt), 32'(1));
    tick("clr_alone");
    ovf_clr = 1'b0;
    chk("clr_ovf",  32'(overflow), 32'(0));
    chk("clr_drop", 32'(drop_cnt), 32'(0));

    // Drain the full queue; tags wrap through the scoreboard.
    evt_ready = 1'b1;
    repeat (15) tick("drain");
    chk("drain_idle", 32'(evt_valid), 32'(0));
    evt_ready = 1'b0;

    // Reset mid-queue between edges clears outputs at once.
    evt_pulse = 1'b1;
    repeat (5) tick("pre_rst");
    evt_pulse = 1'b0;
    chk("pre_rst_pend",  32'(pending),   32'(5));
    chk("pre_rst_valid", 32'(evt_valid), 32'(1));
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_pend",  32'(pending),   32'(0));
    chk("midrst_valid", 32'(evt_valid), 32'(0));
    chk("midrst_seq",   32'(evt_seq),   32'(0));
    chk("midrst_ovf",   32'(overflow),  32'(0));
    chk("midrst_drop",  32'(drop_cnt),  32'(0));
    model_reset();
    @(negedge clkB);
    resetn = 1'b1;
    @(posedge clkB);
    #1;

    evt_ready = 1'b1;
    evt_pulse = 1'b1;
    tick("post_rst_pulse");
    evt_pulse = 1'b0;
    chk("post_rst_seq", 32'(evt_seq), 32'(0));
    tick("post_rst_hs");

    // Nine events: tags 1..7, 0, 1 continuing the wrap.
    evt_ready = 1'b0;
    evt_pulse = 1'b1;
    repeat (9) tick("wrap_fill");
    evt_pulse = 1'b0;
    evt_ready = 1'b1;
    repeat (9) tick("wrap_drain");
    chk("wrap_final_seq", 32'(evt_seq), 32'(2));
    chk("wrap_sb_empty",  32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
